// File: rtl/step_phase_decoder.sv
// Reconstructs stepper motion (steps, direction, signed position, activity)
// from the 4-bit unipolar coil pattern; illegal or skipped phases latch err.
`timescale 1ns/1ps
module step_phase_decoder #(
    parameter int POS_W       = 16,
    parameter int IDLE_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       i_signal,
    input  logic             i_clear,
    output logic [POS_W-1:0] o_position,
    output logic             o_stepPulse,
    output logic             o_dir,
    output logic             o_armed,
    output logic             o_moving,
    output logic             o_err
);

    localparam int                IDLE_W   = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

    localparam logic [0:0] ST_OFF   = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    logic [3:0]        r_sigQ;
    logic [0:0]        r_state;
    logic [1:0]        r_phase;
    logic [POS_W-1:0]  r_position;
    logic              r_stepPulse;
    logic              r_dir;
    logic              r_err;
    logic              r_seen;
    logic [IDLE_W-1:0] r_idle;

    logic              w_isPhase;
    logic              w_isOff;
    logic [1:0]        w_sigIdx;
    logic [1:0]        w_phaseFwd;
    logic [1:0]        w_phaseRev;
    logic [1:0]        w_phaseOpp;
    logic [0:0]        w_nextState;
    logic [1:0]        w_nextPhase;
    logic              w_stepFwd;
    logic              w_stepRev;
    logic              w_setErr;

    // Phases are indexed in forward ring order (P1,P4,P3,P2) so that the
    // successor, predecessor and opposite phase are simple modulo-4 offsets.
    always_comb begin
        w_isPhase = 1'b1;
        w_isOff   = 1'b0;
        w_sigIdx  = 2'd0;
        case (r_sigQ)
            4'b1001: w_sigIdx = 2'd0;
            4'b1100: w_sigIdx = 2'd1;
            4'b0110: w_sigIdx = 2'd2;
            4'b0011: w_sigIdx = 2'd3;
            4'b0000: begin
                w_isPhase = 1'b0;
                w_isOff   = 1'b1;
            end
            default: w_isPhase = 1'b0;
        endcase
    end

    assign w_phaseFwd = r_phase + 2'd1;
    assign w_phaseRev = r_phase - 2'd1;
    assign w_phaseOpp = r_phase + 2'd2;

    always_comb begin
        w_nextState = r_state;
        w_nextPhase = r_phase;
        w_stepFwd   = 1'b0;
        w_stepRev   = 1'b0;
        w_setErr    = 1'b0;
        if (r_state == ST_OFF) begin
            if (w_isPhase) begin
                w_nextState = ST_ARMED;
                w_nextPhase = w_sigIdx;
            end else if (!w_isOff) begin
                w_setErr = 1'b1;
            end
        end else begin
            if (w_isOff) begin
                w_nextState = ST_OFF;
            end else if (!w_isPhase) begin
                w_setErr    = 1'b1;
                w_nextState = ST_OFF;
            end else if (w_sigIdx == w_phaseFwd) begin
                w_stepFwd   = 1'b1;
                w_nextPhase = w_sigIdx;
            end else if (w_sigIdx == w_phaseRev) begin
                w_stepRev   = 1'b1;
                w_nextPhase = w_sigIdx;
            end else if (w_sigIdx == w_phaseOpp) begin
                // A skipped phase is flagged but the decoder resynchronises to it.
                w_setErr    = 1'b1;
                w_nextPhase = w_sigIdx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sigQ      <= 4'b0000;
            r_state     <= ST_OFF;
            r_phase     <= 2'd0;
            r_position  <= '0;
            r_stepPulse <= 1'b0;
            r_dir       <= 1'b0;
            r_err       <= 1'b0;
            r_seen      <= 1'b0;
            r_idle      <= IDLE_MAX;
        end else begin
            r_sigQ <= i_signal;
            if (i_clear) begin
                r_state     <= ST_OFF;
                r_phase     <= 2'd0;
                r_position  <= '0;
                r_stepPulse <= 1'b0;
                r_err       <= 1'b0;
                r_seen      <= 1'b0;
                r_idle      <= IDLE_MAX;
            end else begin
                r_state     <= w_nextState;
                r_phase     <= w_nextPhase;
                r_stepPulse <= w_stepFwd | w_stepRev;
                if (w_setErr) begin
                    r_err <= 1'b1;
                end
                if (w_stepFwd) begin
                    r_position <= r_position + POS_W'(1);
                    r_dir      <= 1'b0;
                end else if (w_stepRev) begin
                    r_position <= r_position - POS_W'(1);
                    r_dir      <= 1'b1;
                end
                if (w_stepFwd | w_stepRev) begin
                    r_idle <= '0;
                    r_seen <= 1'b1;
                end else if (r_idle != IDLE_MAX) begin
                    r_idle <= r_idle + IDLE_W'(1);
                end
            end
        end
    end

    assign o_position  = r_position;
    assign o_stepPulse = r_stepPulse;
    assign o_dir       = r_dir;
    assign o_armed     = (r_state == ST_ARMED);
    assign o_moving    = r_seen && (r_idle < IDLE_MAX);
    assign o_err       = r_err;

endmodule

// File: doc/step_phase_decoder.md
# step_phase_decoder

Monitors the 4-bit coil drive pattern of a unipolar stepper channel and reconstructs motion from it: legal step transitions, direction, signed position and a motion-active flag. It sits alongside the step motor driver and taps the same `signal` bus to feed odometry and self-check logic. Illegal or skipped phase transitions raise a sticky error so the car controller can halt.

## Interface
- `POS_W`, 16, width of the signed position counter (two's complement)
- `IDLE_CYCLES`, 1024, number of clocks with no step after which `moving` drops (≥2)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `signal`  in  4  coil pattern from the driver, synchronous to `clk`
- `clear`  in  1  synchronous clear of `position`, `err`, idle counter and phase state
- `position`  out  POS_W  signed step count: +1 per forward step, −1 per reverse step
- `step_pulse`  out  1  one-cycle strobe per legal step
- `dir`  out  1  direction of last legal step: 0 forward (right), 1 reverse (left)
- `armed`  out  1  decoder holds a valid current phase
- `moving`  out  1  a legal step occurred within the last `IDLE_CYCLES` clocks
- `err`  out  1  sticky illegal-transition flag

## Operation
- Phase codes: P1=1001, P4=1100, P3=0110, P2=0011; OFF=0000. Any other code is ILLEGAL.
- Forward ring (dir=0): P1→P4→P3→P2→P1. Reverse ring (dir=1): P1→P2→P3→P4→P1.
- `signal` registered into `sig_q` every cycle; decode compares `sig_q` against stored state `{armed, phase}`.
- State OFF (armed=0):
  - sig_q OFF: stay.
  - sig_q any phase: arm with that phase; no step, no position change, no error.
  - sig_q ILLEGAL: err←1, stay OFF.
- State ARMED at phase Pk:
  - sig_q == Pk: hold, no step.
  - sig_q = forward successor: phase←succ, step_pulse, dir←0, position+1.
  - sig_q = reverse successor: phase←pred, step_pulse, dir←1, position−1.
  - sig_q = opposite phase (two-step skip, e.g. P1→P3): err←1, rebase phase to sig_q, no count, `dir` unchanged.
  - sig_q OFF: disarm, no count, no error.
  - sig_q ILLEGAL: err←1, disarm.
- Position wraps modulo 2^POS_W (0x7FFF+1 → 0x8000; 0x0000−1 → 0xFFFF for POS_W=16).
- Idle counter: reset to 0 on each step; else increments, saturating at `IDLE_CYCLES`. `moving` = step seen since reset/clear and counter < `IDLE_CYCLES`.
- `err` clears only on `clear` or reset.
- `clear` priority: over any step/error decoded in the same cycle; position←0, err←0, idle counter←saturated (moving=0), state←OFF; `sig_q` still captures normally.

## Timing
- Reset (rst_n=0, async): sig_q=0000, OFF, position=0, step_pulse=0, dir=0, armed=0, moving=0, err=0.
- Release of rst_n takes effect at the next rising edge; no output changes before it.
- Latency: `signal` sampled at edge k → `step_pulse`, `position`, `dir`, `armed`, `err` updated at edge k+1 (2-cycle input-to-output).
- Throughput: one step per clock sustained (driver's maximum rate); back-to-back steps give back-to-back `step_pulse`.
- `step_pulse` high exactly one cycle per step; never high in the cycle `clear` is applied.
- `moving` falls on the cycle the idle counter reaches `IDLE_CYCLES` (step at edge k → moving low after edge k+1+IDLE_CYCLES).
- Reset asserted mid-sequence: all state cleared immediately; first phase after release arms without counting.

## Test plan
- Reset, then signal OFF→1001→1100→0110→0011→1001 one per clock → armed after first, 4 step_pulses, dir=0, position=4, err=0.
- From armed P1, drive 0011,0110,1100,1001,0011 → 5 pulses, dir=1, position=−1 (0xFFFF) after starting at 4−... verify position decrements by 5.
- Armed P1, drive 0110 (skip) → err=1, no pulse, position unchanged; next 0011 counts as forward step from P3.
- Drive 1111 while armed → err=1, armed=0; then 1001 re-arms without step; assert clear same cycle as a legal step → position=0, err=0, no pulse.
- Preload position 0x7FFF via 32767 forward steps, one more → 0x8000; then idle IDLE_CYCLES+2 clocks → moving drops exactly per Timing.
- Pull rst_n low mid-stream between edges → outputs zero immediately; after release, hold phase steady → no pulse, armed=1.
